eviction_status_tracker_mc: RTL

Multi-channel successor to the single-channel eviction status tracker. Captures per-channel eviction events (random / multi-expiry / single-expiry) together with the zero-indexed reference count and the source channel id, and stores them in an on-chip trace buffer. The buffer supports stall-on-full or circular-overwrite mode. It sits beside the cache controllers (one channel per cache/core) and is drained by the performance controller.

---
 rtl/eviction_status_tracker_mc.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/eviction_status_tracker_mc.sv
// Multi-channel eviction tracker: per-channel pending slots, round-robin drain into a trace buffer.
// Defining EVICT_TRACKER_TIMESTAMP_EN adds a 32-bit cycle timestamp per entry (timestamp_o).
module eviction_status_tracker_mc #(
  parameter int N_CHANNELS   = 4,
  parameter int COUNTER_BW   = 32,
  parameter int BUFFER_DEPTH = 1024,
  localparam int BW_CH       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int BW_BUFFER   = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  wrap_mode_i,
  input  logic [N_CHANNELS-1:0] random_evict_i,
  input  logic [N_CHANNELS-1:0] multi_expiry_i,
  input  logic [N_CHANNELS-1:0] expiry_i,
  input  logic [COUNTER_BW-1:0] reference_counter_i,
  input  logic [BW_BUFFER-1:0]  rd_addr_i,
  output logic                  stall_o,
  output logic                  full_o,
  output logic [31:0]           count_o,
  output logic [31:0]           overflow_count_o,
  output logic [COUNTER_BW-1:0] trace_o,
  output logic [1:0]            status_o,
`ifdef EVICT_TRACKER_TIMESTAMP_EN
  output logic [31:0]           timestamp_o,
`endif
  output logic [BW_CH-1:0]      channel_o
);

  localparam logic [BW_BUFFER:0] L_DEPTH = (BW_BUFFER+1)'(BUFFER_DEPTH);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [4:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [N_CHANNELS-1:0] r_pend_vld;
  logic [1:0]            r_pend_code  [N_CHANNELS];
  logic [COUNTER_BW-1:0] r_pend_trace [N_CHANNELS];
  logic [BW_CH-1:0]      r_last;
  logic [BW_BUFFER-1:0]  r_wrptr;
  logic [BW_BUFFER:0]    r_count;
  logic                  r_full, r_stall, r_wrapped;
  logic [31:0]           r_ovf;

  logic [1:0]            r_mem_code  [BUFFER_DEPTH];
  logic [COUNTER_BW-1:0] r_mem_trace [BUFFER_DEPTH];
  logic [BW_CH-1:0]      r_mem_ch    [BUFFER_DEPTH];

  logic [N_CHANNELS-1:0] w_evt, w_gnt_hit, w_take;
  logic [1:0]            w_code [N_CHANNELS];
  logic [COUNTER_BW-1:0] w_ref_m1;
  logic                  w_gnt_vld, w_can_write, w_wr;
  logic [BW_CH-1:0]      w_gnt;
  logic [4:0]            w_drops;
  logic [BW_BUFFER-1:0]  w_rd_idx;

`ifdef EVICT_TRACKER_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_pend_ts [N_CHANNELS];
  logic [31:0] r_mem_ts  [BUFFER_DEPTH];
  logic [31:0] r_ts_o;
  assign timestamp_o = r_ts_o;
`endif

  assign w_ref_m1    = reference_counter_i - COUNTER_BW'(1);
  assign w_can_write = wrap_mode_i || (r_count != L_DEPTH);
  assign w_wr        = w_gnt_vld && w_can_write && !clear_i;
  assign w_rd_idx    = r_wrapped ? (r_wrptr + rd_addr_i) : rd_addr_i;

  // Event encode, drop detection; random outranks multi-expiry outranks expiry
  always_comb begin
    w_drops = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      w_evt[c]     = enable_i && (random_evict_i[c] || multi_expiry_i[c] || expiry_i[c]);
      w_code[c]    = random_evict_i[c] ? 2'b10 : (multi_expiry_i[c] ? 2'b00 : 2'b01);
      w_gnt_hit[c] = w_wr && (w_gnt == BW_CH'(c));
      w_take[c]    = w_evt[c] && (!r_pend_vld[c] || w_gnt_hit[c]);
      if (w_evt[c] && r_pend_vld[c] && !w_gnt_hit[c]) w_drops = w_drops + 5'd1;
    end
  end

  // Round-robin search starting one past the last granted slot
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      idx = int'(r_last) + 1 + i;
      if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
      if (!w_gnt_vld && r_pend_vld[BW_CH'(idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = BW_CH'(idx);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      r_pend_vld <= '0;
      r_last     <= BW_CH'(N_CHANNELS - 1);
      r_wrptr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_stall    <= 1'b0;
      r_wrapped  <= 1'b0;
      r_ovf      <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (w_take[c])         r_pend_vld[c] <= 1'b1;
        else if (w_gnt_hit[c]) r_pend_vld[c] <= 1'b0;
      end
      if (w_wr) begin
        r_last  <= w_gnt;
        r_wrptr <= r_wrptr + 1'b1;
        if (r_count != L_DEPTH) r_count <= r_count + 1'b1;
        if (r_count == L_DEPTH - 1'b1) begin
          r_full  <= 1'b1;
          r_stall <= !wrap_mode_i;
        end
        if (wrap_mode_i && (r_wrptr == '1)) r_wrapped <= 1'b1;
      end
      r_ovf <= sat_add(r_ovf, w_drops);
    end
  end

  // Pending payload and buffer storage carry no reset
  always_ff @(posedge clock_i) begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (w_take[c]) begin
        r_pend_code[c]  <= w_code[c];
        r_pend_trace[c] <= w_ref_m1;
`ifdef EVICT_TRACKER_TIMESTAMP_EN
        r_pend_ts[c]    <= r_ts;
`endif
      end
    end
    if (w_wr) begin
      r_mem_code[r_wrptr]  <= r_pend_code[w_gnt];
      r_mem_trace[r_wrptr] <= r_pend_trace[w_gnt];
      r_mem_ch[r_wrptr]    <= w_gnt;
`ifdef EVICT_TRACKER_TIMESTAMP_EN
      r_mem_ts[r_wrptr]    <= r_pend_ts[w_gnt];
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      trace_o   <= '0;
      status_o  <= '0;
      channel_o <= '0;
`ifdef EVICT_TRACKER_TIMESTAMP_EN
      r_ts_o    <= '0;
`endif
    end else begin
      trace_o   <= r_mem_trace[w_rd_idx];
      status_o  <= r_mem_code[w_rd_idx];
      channel_o <= r_mem_ch[w_rd_idx];
`ifdef EVICT_TRACKER_TIMESTAMP_EN
      r_ts_o    <= r_mem_ts[w_rd_idx];
`endif
    end
  end

`ifdef EVICT_TRACKER_TIMESTAMP_EN
  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) r_ts <= '0;
    else                    r_ts <= r_ts + 32'd1;
  end
`endif

  assign stall_o          = r_stall;
  assign full_o           = r_full;
  assign count_o          = 32'(r_count);
  assign overflow_count_o = r_ovf;

endmodule
